// File: rtl/des_subkey_gen_dec.sv
// rtl/des_subkey_gen_dec.sv - DES key schedule producing round subkeys in decrypt order
//
// Purpose:
//    Loads a 64-bit DES key, applies PC-1 into a 56-bit C/D register and
//    streams the 16 round subkeys (PC-2 of C/D) over a valid/ready
//    handshake. The default order is decrypt, K16 down to K1.
//
// Ports:
//    clk           in   1   system clock, rising edge
//    rst           in   1   asynchronous active-high reset
//    start         in   1   load key and begin a sequence (sampled in IDLE only)
//    key           in  64   DES key, FIPS bit 1 = key[63], parity bits ignored
//    mode          in   1   (DES_KSCHED_BIDIR_EN only) 1 = decrypt order, 0 = encrypt order
//    subkey        out 48   PC-2 of the current C/D register, FIPS bit 1 = subkey[47]
//    subkey_valid  out  1   subkey/round_idx are valid
//    subkey_ready  in   1   consumer accepts the subkey
//    round_idx     out  4   round number minus 1 of the presented subkey
//    busy          out  1   state is not IDLE
//    done          out  1   one-cycle pulse after the final transfer
//
// Configuration macro: DES_KSCHED_BIDIR_EN adds the mode port and encrypt order.

module des_subkey_gen_dec (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] key,
`ifdef DES_KSCHED_BIDIR_EN
   input  logic        mode,
`endif
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round_idx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      FIN  = 2'd2
   } state_t;

   // FIPS 46 PC-1, 1-based key bit numbers, first entry becomes C/D bit 1.
   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   // FIPS 46 PC-2, 1-based C/D bit numbers, first entry becomes subkey bit 1.
   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Bit i set means round i+1 shifts by two; rounds 1, 2, 9 and 16 shift by one.
   localparam logic [15:0] SHIFT2 = 16'h7EFC;

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r = {r[54:0], k[6'(64 - PC1_TBL[i])]};
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         r = {r[46:0], cd[6'(56 - PC2_TBL[i])]};
      end
      return r;
   endfunction

   // Rotates the C and D halves independently by one or two places.
   function automatic logic [55:0] rot(input logic [55:0] cd, input logic two, input logic left);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (left) begin
         c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
         d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
      end else begin
         c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
         d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
      end
      return {c, d};
   endfunction

   state_t      state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  round_q, round_d;
   logic        dec_q, dec_d;
   logic        xfer;
   logic        last_xfer;

   assign xfer = (state_q == EMIT) & subkey_ready;

   // Decrypt order ends on round index 0, encrypt order on 15.
   assign last_xfer = xfer & (dec_q ? (round_q == 4'd0) : (round_q == 4'd15));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = EMIT;
         EMIT:    if (last_xfer) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      subkey_valid = (state_q == EMIT);
      busy         = (state_q != IDLE);
      done         = (state_q == FIN);
   end

   // ---------------- key schedule datapath ----------------
   always_comb begin
      cd_d    = cd_q;
      round_d = round_q;
      dec_d   = dec_q;
      if ((state_q == IDLE) && start) begin
`ifdef DES_KSCHED_BIDIR_EN
         dec_d = mode;
         if (mode) begin
            cd_d    = pc1(key);
            round_d = 4'd15;
         end else begin
            // Encrypt order presents K1 first, which needs C1/D1.
            cd_d    = rot(pc1(key), SHIFT2[0], 1'b1);
            round_d = 4'd0;
         end
`else
         dec_d   = 1'b1;
         // C16/D16 equals C0/D0, so K16 comes straight from PC-1.
         cd_d    = pc1(key);
         round_d = 4'd15;
`endif
      end else if (xfer && !last_xfer) begin
         if (dec_q) begin
            // Undo the left shift of round r+1 to step from K(r+1) to K(r).
            cd_d    = rot(cd_q, SHIFT2[round_q], 1'b0);
            round_d = round_q - 4'd1;
         end else begin
            // Apply the left shift of round r+2 to step from K(r+1) to K(r+2).
            cd_d    = rot(cd_q, SHIFT2[round_q + 4'd1], 1'b1);
            round_d = round_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cd_q    <= '0;
         round_q <= '0;
         dec_q   <= 1'b1;
      end else begin
         cd_q    <= cd_d;
         round_q <= round_d;
         dec_q   <= dec_d;
      end
   end

   assign subkey    = pc2(cd_q);
   assign round_idx = round_q;

endmodule

// File: tb/tb_des_subkey_gen_dec.sv
// tb/tb_des_subkey_gen_dec.sv - directed self-checking bench for des_subkey_gen_dec

module tb_des_subkey_gen_dec;

   localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
   localparam logic [63:0] PARITY = 64'h0101010101010101;

   // Index is round number minus 1 (K1 .. K16).
   localparam logic [47:0] EXP_K [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] key;
   logic        mode;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [3:0]  round_idx;
   logic        busy;
   logic        done;

   int tests;
   int fails;

   des_subkey_gen_dec dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .key          (key),
`ifdef DES_KSCHED_BIDIR_EN
      .mode         (mode),
`endif
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .round_idx    (round_idx),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      tests++;
      if (subkey_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL %s: valid=%b busy=%b done=%b, required 0 0 0", name, subkey_valid, busy, done);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check_idle(name);
      tests++;
      if (subkey !== 48'h0 || round_idx !== 4'd0) begin
         fails++;
         $display("FAIL %s_data: subkey=%h idx=%0d, required 000000000000 0", name, subkey, round_idx);
      end
   endtask

   task automatic do_start(input logic [63:0] k, input logic m);
      key   = k;
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode  = ~m;
      key   = {$urandom, $urandom};
   endtask

   // Runs one full sequence from the cycle after start through the idle cycles after done.
   task automatic run_seq(input string name, input bit dec, input bit rand_ready, input bit poke);
      int          n;
      int          cyc;
      int          ridx;
      bit          rdy;
      bit          stalled;
      logic [47:0] held_k;
      logic [3:0]  held_r;
      n       = 0;
      cyc     = 0;
      stalled = 1'b0;
      held_k  = '0;
      held_r  = '0;
      while (n < 16 && cyc < 200) begin
         rdy          = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         subkey_ready = rdy;
         if (poke) begin
            start = 1'($urandom_range(0, 1));
            key   = {$urandom, $urandom};
         end
         tests++;
         if (subkey_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_emit n=%0d: valid=%b busy=%b done=%b, required 1 1 0",
                     name, n, subkey_valid, busy, done);
         end
         if (stalled) begin
            tests++;
            if (subkey !== held_k || round_idx !== held_r) begin
               fails++;
               $display("FAIL %s_stall n=%0d: subkey=%h idx=%0d, required %h %0d",
                        name, n, subkey, round_idx, held_k, held_r);
            end
         end
         if (rdy) begin
            ridx = dec ? 15 - n : n;
            tests++;
            if (subkey !== EXP_K[ridx] || round_idx !== 4'(ridx)) begin
               fails++;
               $display("FAIL %s_subkey n=%0d: subkey=%h idx=%0d, required %h %0d",
                        name, n, subkey, round_idx, EXP_K[ridx], ridx);
            end
            n++;
         end
         stalled = !rdy;
         held_k  = subkey;
         held_r  = round_idx;
         tick();
         cyc++;
      end
      tests++;
      if (n != 16) begin
         fails++;
         $display("FAIL %s_timeout: transfers=%0d, required 16", name, n);
      end
      subkey_ready = 1'b1;
      start        = poke;
      tests++;
      if (done !== 1'b1 || subkey_valid !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL %s_fin: done=%b valid=%b busy=%b, required 1 0 1", name, done, subkey_valid, busy);
      end
      tick();
      start = 1'b0;
      check_idle({name, "_idle0"});
      tick();
      check_idle({name, "_idle1"});
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      start        = 1'b0;
      key          = KEY;
      mode         = 1'b1;
      subkey_ready = 1'b0;
      #2;
      check_reset_vals("reset_async");
      tick();
      start = 1'b1;
      tick();
      check_reset_vals("reset_held");
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check_reset_vals("reset_release");
   endtask

   task automatic test_decrypt_stream();
      do_start(KEY, 1'b1);
      run_seq("dec_stream", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random_stall();
      do_start(KEY, 1'b1);
      run_seq("dec_stall", 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_start_ignored();
      do_start(KEY, 1'b1);
      run_seq("start_busy", 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_async_reset();
      do_start(KEY, 1'b1);
      subkey_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (subkey !== EXP_K[15 - i] || subkey_valid !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre n=%0d: subkey=%h valid=%b, required %h 1",
                     i, subkey, subkey_valid, EXP_K[15 - i]);
         end
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("abort_rst");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle("abort_quiet");
         tick();
      end
      do_start(KEY, 1'b1);
      run_seq("abort_restart", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_parity();
      do_start(KEY ^ PARITY, 1'b1);
      run_seq("dec_parity", 1'b1, 1'b1, 1'b0);
   endtask

`ifdef DES_KSCHED_BIDIR_EN
   task automatic test_encrypt();
      do_start(KEY, 1'b0);
      run_seq("enc_stream", 1'b0, 1'b0, 1'b0);
      do_start(KEY ^ PARITY, 1'b0);
      run_seq("enc_parity", 1'b0, 1'b1, 1'b1);
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_decrypt_stream();
      test_random_stall();
      test_start_ignored();
      test_async_reset();
      test_parity();
`ifdef DES_KSCHED_BIDIR_EN
      test_encrypt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
